// File: rtl/arb.sv
// Two-master round-robin bus arbiter (DMA vs TDSP) with registered grants.
// Define ARB_HOLD_LIMIT_EN to preempt a holder after MAX_HOLD contended cycles.
module arb #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_breq,
    input  logic tdsp_breq,
    output logic dma_grant,
    output logic tdsp_grant
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_DMA  = 2'd1,
        GNT_TDSP = 2'd2
    } state_e;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("arb: MAX_HOLD must be in 2..255");
    end

    state_e state_q, state_d;
    logic   last_dma_q, last_dma_d;
    logic   dma_grant_q, tdsp_grant_q;

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
`endif

    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
`ifdef ARB_HOLD_LIMIT_EN
        hold_d     = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dma_breq && tdsp_breq)
                    state_d = last_dma_q ? GNT_TDSP : GNT_DMA;
                else if (dma_breq)
                    state_d = GNT_DMA;
                else if (tdsp_breq)
                    state_d = GNT_TDSP;
            end
            GNT_DMA: begin
                if (!dma_breq)
                    state_d = tdsp_breq ? GNT_TDSP : IDLE;
`ifdef ARB_HOLD_LIMIT_EN
                else if (tdsp_breq) begin
                    if (hold_q == HOLD_LAST)
                        state_d = GNT_TDSP;
                    else
                        hold_d = hold_q + 8'd1;
                end
`endif
            end
            GNT_TDSP: begin
                if (!tdsp_breq)
                    state_d = dma_breq ? GNT_DMA : IDLE;
`ifdef ARB_HOLD_LIMIT_EN
                else if (dma_breq) begin
                    if (hold_q == HOLD_LAST)
                        state_d = GNT_DMA;
                    else
                        hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Round-robin memory and hold count refresh only on entry to a grant.
        if (state_d == GNT_DMA && state_q != GNT_DMA) begin
            last_dma_d = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_d     = 8'd0;
`endif
        end
        if (state_d == GNT_TDSP && state_q != GNT_TDSP) begin
            last_dma_d = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_d     = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_dma_q   <= 1'b0;
            dma_grant_q  <= 1'b0;
            tdsp_grant_q <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_dma_q   <= last_dma_d;
            dma_grant_q  <= (state_d == GNT_DMA);
            tdsp_grant_q <= (state_d == GNT_TDSP);
`ifdef ARB_HOLD_LIMIT_EN
            hold_q       <= hold_d;
`endif
        end
    end

    assign dma_grant  = dma_grant_q;
    assign tdsp_grant = tdsp_grant_q;

endmodule

// File: tb/tb_arb.sv
// Directed-vector bench for arb: reset, latency, round-robin, abort,
// hold limit (ARB_HOLD_LIMIT_EN) and a randomised fairness soak.
module tb_arb;

    logic clk = 1'b0;
    logic reset;
    logic dma_breq;
    logic tdsp_breq;
    logic dma_grant;
    logic tdsp_grant;

    int n_vec = 0;
    int n_bad = 0;
    int overlap = 0;
    int gd_cnt = 0;
    int gt_cnt = 0;

    always #5 clk = ~clk;

    arb #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .dma_breq  (dma_breq),
        .tdsp_breq (tdsp_breq),
        .dma_grant (dma_grant),
        .tdsp_grant(tdsp_grant)
    );

    always @(negedge clk)
        if (dma_grant === 1'b1 && tdsp_grant === 1'b1)
            overlap++;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset     = 1'b1;
        dma_breq  = 1'b0;
        tdsp_breq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Bit c of each mask is the request level / expected grant in cycle c.
    task automatic run(input string tag, input int n,
                       input logic [31:0] dreq, input logic [31:0] treq,
                       input logic [31:0] dg, input logic [31:0] tg);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk($sformatf("%s.dg[%0d]", tag, c), int'(dma_grant), int'(dg[c]));
            chk($sformatf("%s.tg[%0d]", tag, c), int'(tdsp_grant), int'(tg[c]));
            dma_breq  = dreq[c];
            tdsp_breq = treq[c];
        end
    endtask

    task automatic dma_master(input int wd, input int budget);
        int cnt;
        repeat (wd) @(negedge clk);
        dma_breq = 1'b1;
        cnt = 0;
        while (dma_grant !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        chk("soak.dma_granted", int'(dma_grant), 1);
        if (dma_grant === 1'b1) gd_cnt++;
        dma_breq = 1'b0;
    endtask

    task automatic tdsp_master(input int wt, input int budget);
        int cnt;
        repeat (wt) @(negedge clk);
        tdsp_breq = 1'b1;
        cnt = 0;
        while (tdsp_grant !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        chk("soak.tdsp_granted", int'(tdsp_grant), 1);
        if (tdsp_grant === 1'b1) gt_cnt++;
        tdsp_breq = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        dma_breq  = 1'b1;
        tdsp_breq = 1'b1;

        // Reset held 3 cycles with both requests up; DMA wins first tie.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.dg", int'(dma_grant), 0);
            chk("rst.tg", int'(tdsp_grant), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tie.dg", int'(dma_grant), 1);
        chk("rst_tie.tg", int'(tdsp_grant), 0);
        dma_breq  = 1'b0;
        tdsp_breq = 1'b0;
        @(negedge clk);
        chk("rst_rel.dg", int'(dma_grant), 0);

        // DMA alone: request cycles 10-11, grant cycles 11-12.
        reset_dut();
        run("solo", 16, 32'h0C00, 32'h0000, 32'h1800, 32'h0000);

        // Simultaneous requests: DMA first, then clean handoff to TDSP.
        reset_dut();
        run("tieA", 8, 32'h0003, 32'h000F, 32'h0006, 32'h0018);
        run("dma1", 5, 32'h0003, 32'h0000, 32'h0006, 32'h0000);
        // DMA was last, so the next tie goes to TDSP.
        run("tieB", 8, 32'h000F, 32'h0003, 32'h0018, 32'h0006);

        // Abort mid-grant, then TDSP re-granted 1 cycle after reset drops.
        reset_dut();
        @(negedge clk);
        tdsp_breq = 1'b1;
        @(negedge clk);
        chk("abort.pre_tg", int'(tdsp_grant), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.tg", int'(tdsp_grant), 0);
        chk("abort.dg", int'(dma_grant), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort.regrant", int'(tdsp_grant), 1);
        tdsp_breq = 1'b0;
        @(negedge clk);
        chk("abort.release", int'(tdsp_grant), 0);

        reset_dut();
`ifdef ARB_HOLD_LIMIT_EN
        // DMA preempted after 4 contended cycles (3..6), TDSP from cycle 7.
        run("hold", 16, 32'h0FFF, 32'h00F8, 32'h1E7E, 32'h0180);
`else
        // No limit: DMA keeps the bus until it lets go.
        run("hold", 18, 32'h0FFF, 32'h3FF8, 32'h1FFE, 32'h6000);
`endif

        // Randomised symmetric traffic.
        reset_dut();
        overlap = 0;
        for (int r = 0; r < 256; r++) begin
            int wd;
            int wt;
            int budget;
            wd = int'($urandom_range(31, 0));
            wt = int'($urandom_range(31, 0));
            budget = wd + wt + 10;
            fork
                dma_master(wd, budget);
                tdsp_master(wt, budget);
            join
            repeat (2) @(negedge clk);
        end
        chk("soak.dma_count", gd_cnt, 256);
        chk("soak.tdsp_count", gt_cnt, 256);
        chk("soak.overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
